dec_scan_seq: RTL
=================

DEC_SCAN_SEQ -- requirements
Module: dec_scan_seq

Interface
REQ-001 Parameter PRESCALE, default 4: clock cycles each address is held; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begins a scan when sampled high in IDLE.
REQ-005 stop  input  1  aborts a scan; takes effect on the next edge.
REQ-006 mode  input  1  0 = continuous wrap, 1 = single pass of 16 addresses.
REQ-007 dir  input  1  0 = count up, 1 = count down; sampled at every step tick.
REQ-008 load  input  1  in IDLE, loads load_val into w.
REQ-009 load_val  input  4  start address for the next scan.
REQ-010 w  output  4  registered address to the 4-to-16 decoder w input.
REQ-011 en  output  1  registered decoder enable; high only while scanning.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse at the end of a single pass.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and FINISH; all outputs are registered.
REQ-015 IDLE: en=0, busy=0, done=0; start=1 and stop=0 -> RUN; the prescale counter and step counter clear to 0.
REQ-016 IDLE with load=1 SHALL set w<=load_val at the next edge; load with start in the same cycle loads and starts, so the first address is load_val.
REQ-017 RUN: en=1, busy=1 from the first edge after start; latency start->en is 1 cycle, and w is unchanged on entry.
REQ-018 A tick SHALL occur when the prescale counter equals PRESCALE-1, after which the counter wraps to 0; PRESCALE=1 ticks every RUN cycle.
REQ-019 On a tick, w SHALL step +1 (dir=0) or -1 (dir=1) modulo 16: 15->0 and 0->15.
REQ-020 mode=1: a tick with step counter == 15 SHALL go to FINISH without stepping w; otherwise w steps and the counter increments, so 16 addresses are held PRESCALE cycles each.
REQ-021 mode=0: the step counter is ignored and RUN continues indefinitely.
REQ-022 FINISH lasts exactly one cycle: done=1, en=0, busy=0, w holds the last address; then IDLE.
REQ-023 stop=1 in RUN SHALL force IDLE at the next edge, with en=0, w held and no done pulse; stop has priority over a coincident tick.
REQ-024 In IDLE, start and stop high together SHALL leave the FSM in IDLE.
REQ-025 start and load SHALL be ignored in RUN and FINISH; mode is sampled only at start.

Reset
REQ-026 While rst=1, asynchronously: w=0, en=0, busy=0, done=0, state=IDLE, prescale and step counters=0; this overrides any operation in progress.
REQ-027 After rst deasserts, no scan SHALL begin without a fresh start.

Structure
REQ-028 State encodings and the mode/dir codes SHALL live in the shared header dec_seq_defs.vh, included by the RTL and the bench.
REQ-029 The prescaler SHALL be a sub-module tick_gen (inputs clk, rst, clr, run; output tick; parameter PRESCALE).
REQ-030 w and en SHALL connect directly to the decoder w and en ports, with no glue logic.

Verification
REQ-031 PRESCALE=2, mode=1, dir=0, w=0, pulse start -> en=1 next cycle; w sequence 0,0,1,1,...,15,15 over 32 cycles; then done=1 for one cycle, en=0, w=15.
REQ-032 load_val=13 with load, then start, mode=1, dir=1 -> w 13,12,...,0,15,14; done pulse; final w=14.
REQ-033 mode=0, dir=0, start from w=14 -> w 14,15,0,1,...; stop -> en=0 and busy=0 next cycle, w held, done never asserted.
REQ-034 rst asserted mid-RUN with w=9 -> w=0 and en=0 immediately, without a clock edge; idle until the next start.
REQ-035 start and stop together in IDLE -> stays IDLE; load_val=5 with load during RUN -> w sequence unaffected.
REQ-036 dir toggled mid-run with PRESCALE=1 -> w reverses at the next tick, e.g. 3,4,5,4,3.

Source files
------------

// File: rtl/dec_scan_seq_pkg.sv
// Types and helpers for the 4-to-16 decoder scan sequencer.
package dec_scan_seq_pkg;
    `include "dec_seq_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE   = DEC_ST_IDLE,
        ST_RUN    = DEC_ST_RUN,
        ST_FINISH = DEC_ST_FINISH
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd15;

    // Address arithmetic wraps naturally in 4 bits: 15->0 and 0->15.
    function automatic logic [3:0] next_addr(input logic [3:0] addr, input logic dir);
        return (dir == DEC_DIR_DOWN) ? addr - 4'd1 : addr + 4'd1;
    endfunction
endpackage

// File: rtl/dec_scan_seq_tick_gen.sv
// Prescaler: pulses tick on the last cycle of every PRESCALE-cycle window while run is high.
module tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    logic [7:0] r_cnt;
    logic       w_at_end;

    assign w_at_end = (r_cnt == 8'(PRESCALE - 1));
    assign tick     = run && !clr && w_at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (run) begin
            r_cnt <= w_at_end ? 8'd0 : r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/dec_seq_defs.vh
// Shared codes for the scan sequencer: FSM state encodings and the mode/dir input values.
// Included by the sequencer package, so the RTL and the bench see the same codes.
`ifndef DEC_SEQ_DEFS_VH
`define DEC_SEQ_DEFS_VH
localparam logic [1:0] DEC_ST_IDLE     = 2'd0;
localparam logic [1:0] DEC_ST_RUN      = 2'd1;
localparam logic [1:0] DEC_ST_FINISH   = 2'd2;
localparam logic       DEC_MODE_CONT   = 1'b0;
localparam logic       DEC_MODE_SINGLE = 1'b1;
localparam logic       DEC_DIR_UP      = 1'b0;
localparam logic       DEC_DIR_DOWN    = 1'b1;
`endif

// File: rtl/dec_scan_seq.sv
// Address scanner driving a 4-to-16 decoder: holds each address PRESCALE cycles,
// either wrapping forever or making one 16-address pass ending in a done pulse.
module dec_scan_seq
    import dec_scan_seq_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] w,
    output logic       en,
    output logic       busy,
    output logic       done
);
    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_w;
    logic [3:0] w_w_next;
    logic [3:0] r_step;
    logic [3:0] w_step_next;
    logic       r_mode;
    logic       w_mode_next;
    logic       r_en;
    logic       r_busy;
    logic       r_done;
    logic       w_tick;
    logic       w_in_run;

    assign w_in_run = (r_state == ST_RUN);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_in_run),
        .run  (w_in_run),
        .tick (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_w_next     = r_w;
        w_step_next  = r_step;
        w_mode_next  = r_mode;
        case (r_state)
            ST_IDLE: begin
                w_step_next = 4'd0;
                if (load) begin
                    w_w_next = load_val;
                end
                if (start && !stop) begin
                    w_state_next = ST_RUN;
                    w_mode_next  = mode;
                end
            end
            ST_RUN: begin
                // stop wins over a coincident tick
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (r_mode == DEC_MODE_SINGLE && r_step == LAST_STEP) begin
                        w_state_next = ST_FINISH;
                    end else begin
                        w_w_next = next_addr(r_w, dir);
                        if (r_mode == DEC_MODE_SINGLE) begin
                            w_step_next = r_step + 4'd1;
                        end
                    end
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_w     <= 4'd0;
            r_step  <= 4'd0;
            r_mode  <= DEC_MODE_CONT;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_w     <= w_w_next;
            r_step  <= w_step_next;
            r_mode  <= w_mode_next;
            r_en    <= (w_state_next == ST_RUN);
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_FINISH);
        end
    end

    // Registers feed the decoder ports directly.
    assign w    = r_w;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;
endmodule
